linebuf_reader: RTL and testbench

LINEBUF_READER -- requirements
Module: linebuf_reader

---
 rtl/linebuf_reader_pkg.sv | 24 ++
 rtl/linebuf_reader.sv | 133 +++++++++++++
 tb/tb_linebuf_reader.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_reader_pkg.sv
// OCP encodings shared by the line buffer and its reader, plus the
// reader's state type.
package linebuf_reader_pkg;

    typedef enum logic [2:0] {
        OCP_CMD_IDLE = 3'b000,
        OCP_CMD_WR   = 3'b001,
        OCP_CMD_RD   = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        OCP_RESP_NULL = 2'b00,
        OCP_RESP_DVA  = 2'b01,
        OCP_RESP_ERR  = 2'b11
    } ocp_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PUSH
    } rd_state_e;

endpackage

// File: rtl/linebuf_reader.sv
// Reads one line of pixels from an OCP line buffer, one read in flight,
// and streams them downstream over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// REQ     | RD command on the bus, address held until accepted
// WAIT    | read accepted, waiting for DVA/ERR or timeout
// PUSH    | pixel presented downstream, waiting for pix_ready
module linebuf_reader
    import linebuf_reader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TMO_CYC = 255
) (
    input  logic              readClk,
    input  logic              readRst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   line_len,
    output logic [2:0]        linebuf_MCmd,
    output logic [ADDR_W-1:0] linebuf_MAddr,
    output logic [DATA_W-1:0] linebuf_MData,
    input  logic              linebuf_SCmdAccept,
    input  logic [DATA_W-1:0] linebuf_SData,
    input  logic [1:0]        linebuf_SResp,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMR_W = $clog2(TMO_CYC + 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge readClk or negedge readRst_n) begin
        if (!readRst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        pix_d   = pix_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d  = 1'b0;
                    addr_d = '0;
                    cnt_d  = line_len;
                    if (line_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Down-counter terminal count at zero gives TMO_CYC+1 WAIT
                // cycles, same as counting up from zero to TMO_CYC.
                if (linebuf_SCmdAccept) begin
                    state_d = ST_WAIT;
                    tmr_d   = TMR_W'(TMO_CYC);
                end
            end
            ST_WAIT: begin
                if (linebuf_SResp == OCP_RESP_DVA) begin
                    pix_d   = linebuf_SData;
                    state_d = ST_PUSH;
                end else if (linebuf_SResp == OCP_RESP_ERR || tmr_q == '0) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_PUSH: begin
                if (pix_ready) begin
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign linebuf_MCmd  = (state_q == ST_REQ) ? OCP_CMD_RD : OCP_CMD_IDLE;
    assign linebuf_MAddr = addr_q;
    assign linebuf_MData = '0;
    assign pix_data      = pix_q;
    assign pix_valid     = (state_q == ST_PUSH);
    assign pix_last      = (state_q == ST_PUSH) && (cnt_q == (ADDR_W+1)'(1));
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_linebuf_reader.sv
// Directed and randomized checks of linebuf_reader against a line-level
// model: expected pixels are mem[0..stop-1], where stop is the first bad address.
module tb_linebuf_reader;
    import linebuf_reader_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 255;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   line_len = '0;
    logic [2:0]        mcmd;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic              acc = 1'b0;
    logic [DATA_W-1:0] sdata = '0;
    logic [1:0]        sresp = 2'b00;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic              pix_last;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    linebuf_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .readClk(clk), .readRst_n(rst_n), .start(start), .line_len(line_len),
        .linebuf_MCmd(mcmd), .linebuf_MAddr(maddr), .linebuf_MData(mdata),
        .linebuf_SCmdAccept(acc), .linebuf_SData(sdata), .linebuf_SResp(sresp),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .done(done), .err(err)
    );

    // Stimulus controls, written only by the main sequence
    int                compared = 0;
    int                mismatched = 0;
    int                line_id = 0;
    int                acc_max = 0, resp_max = 0, rdy_pct = 100;
    int                dly_addr = -1, dly_val = 0;
    int                err_addr = -1;
    int                no_resp_from = DEPTH + 1;
    int                hold_idx = -1, hold_len = 0;
    bit                junk_en = 1'b0;
    logic [DATA_W-1:0] mem [DEPTH];

    // Slave/sink/monitor state, written only by the negedge process
    int                seen_id = 0;
    bit                armed = 0, pending = 0;
    int                acc_cnt = 0, acc_tgt = 0, resp_cnt = 0, resp_tgt = 0, s_addr = 0;
    int                hold_cnt = 0;
    logic [DATA_W-1:0] got_q[$];
    bit                last_q[$];
    int                acc_q[$];
    int                done_cnt = 0, rd_dly_cnt = 0, rd_total = 0, viol = 0, stall_cnt = 0;
    bit                prev_stall = 0, prev_done = 0, prev_last = 0, busy_seen = 0;
    logic [DATA_W-1:0] prev_data = '0;
    int                ncyc = 0, t_acc = 0, t_done = 0;
    logic              rdy_n;

    always @(negedge clk) begin
        ncyc++;
        if (seen_id != line_id) begin
            seen_id = line_id;
            got_q.delete(); last_q.delete(); acc_q.delete();
            done_cnt = 0; rd_dly_cnt = 0; rd_total = 0; viol = 0; stall_cnt = 0;
            busy_seen = 0; hold_cnt = 0;
        end
        if (!rst_n || !busy) begin
            armed = 0;
            pending = 0;
        end
        // Outside an outstanding read the reader must ignore whatever SResp shows
        sresp = OCP_RESP_NULL;
        sdata = DATA_W'($urandom);
        acc   = 1'b0;
        if (junk_en && !pending) begin
            case ($urandom_range(2, 0))
                0: sresp = OCP_RESP_DVA;
                1: sresp = OCP_RESP_ERR;
                default: sresp = OCP_RESP_NULL;
            endcase
        end
        if (mcmd == OCP_CMD_RD && !pending) begin
            if (!armed) begin
                armed   = 1;
                acc_cnt = 0;
                s_addr  = int'(maddr);
                acc_tgt = (s_addr == dly_addr) ? dly_val : int'($urandom_range(acc_max, 0));
            end
            if (int'(maddr) != s_addr) viol++;
            if (s_addr == dly_addr) rd_dly_cnt++;
            rd_total++;
            if (acc_cnt == acc_tgt) begin
                acc      = 1'b1;
                armed    = 0;
                pending  = 1;
                resp_cnt = 0;
                resp_tgt = int'($urandom_range(resp_max, 0));
                acc_q.push_back(s_addr);
                t_acc = ncyc;
            end else begin
                acc_cnt++;
            end
        end else if (pending) begin
            sresp = OCP_RESP_NULL;
            if (s_addr < no_resp_from) begin
                if (resp_cnt == resp_tgt) begin
                    sresp   = (s_addr == err_addr) ? OCP_RESP_ERR : OCP_RESP_DVA;
                    sdata   = mem[s_addr];
                    pending = 0;
                end else begin
                    resp_cnt++;
                end
            end
        end else if (mcmd != OCP_CMD_IDLE) begin
            viol++;
        end

        if (pix_valid && int'(got_q.size()) == hold_idx && hold_cnt < hold_len) begin
            rdy_n = 1'b0;
            hold_cnt++;
        end else begin
            rdy_n = (int'($urandom_range(99, 0)) < rdy_pct);
        end
        pix_ready = rdy_n;
        if (pix_valid) begin
            if (prev_stall && (pix_data !== prev_data || pix_last !== prev_last)) viol++;
            if (mcmd != OCP_CMD_IDLE) viol++;
            if (pix_ready) begin
                got_q.push_back(pix_data);
                last_q.push_back(pix_last);
            end else begin
                stall_cnt++;
            end
        end
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_last  = pix_last;

        if (done) begin
            done_cnt++;
            t_done = ncyc;
            if (busy) viol++;
            if (prev_done) viol++;
        end
        prev_done = done;
        if (busy) busy_seen = 1;
        if (mdata !== '0) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, wait (bounded) for done, return edges from start sample to done.
    task automatic run_line(input string tag, input int len, output int cycles);
        int c;
        line_id++;
        @(negedge clk);
        line_len = (ADDR_W+1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " err cleared"}, err, 0);
        c = 1;
        while (!done && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check({tag, " done seen"}, done, 1);
        cycles = c;
        repeat (2) @(negedge clk);
    endtask

    task automatic verify_line(input string tag, input int len);
        int stop, n_exp, n_req;
        bit exp_err;
        stop = DEPTH + 1;
        if (err_addr >= 0) stop = err_addr;
        if (no_resp_from < stop) stop = no_resp_from;
        exp_err = (stop < len);
        n_exp   = exp_err ? stop : len;
        n_req   = exp_err ? stop + 1 : len;
        check({tag, " pixel count"}, got_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < int'(got_q.size()); i++) begin
            check($sformatf("%s pix[%0d]", tag, i), got_q[i], mem[i]);
            check($sformatf("%s last[%0d]", tag, i), last_q[i], (i == len - 1));
        end
        check({tag, " requests"}, acc_q.size(), n_req);
        if (n_req > 0 && acc_q.size() > 0)
            check({tag, " last addr"}, acc_q[acc_q.size() - 1], n_req - 1);
        check({tag, " err"}, err, exp_err);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " protocol"}, viol, 0);
        check({tag, " busy after"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " MCmd"}, mcmd, OCP_CMD_IDLE);
        check({tag, " MAddr"}, maddr, 0);
        check({tag, " MData"}, mdata, 0);
        check({tag, " pix_data"}, pix_data, 0);
        check({tag, " pix_valid"}, pix_valid, 0);
        check({tag, " pix_last"}, pix_last, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
    endtask

    initial begin
        int cyc, len;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 'h10);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait slave: 3 cycles per pixel, done one edge after the last PUSH
        run_line("basic", 4, cyc);
        verify_line("basic", 4);
        check("basic period", cyc, 3 * 4 + 1);

        // Accept on address 1 delayed 5 cycles: RD/MAddr=1 visible 6 cycles
        dly_addr = 1; dly_val = 5;
        run_line("acc_dly", 3, cyc);
        verify_line("acc_dly", 3);
        check("acc_dly rd cycles", rd_dly_cnt, 6);
        dly_addr = -1;

        // Downstream stalls 4 cycles on the second pixel
        hold_idx = 1; hold_len = 4;
        run_line("stall", 4, cyc);
        verify_line("stall", 4);
        check("stall cycles", stall_cnt, 4);
        hold_idx = -1;

        // ERR on address 2 aborts after two pixels; next start clears err
        err_addr = 2;
        run_line("err", 5, cyc);
        verify_line("err", 5);
        err_addr = -1;
        run_line("after_err", 2, cyc);
        verify_line("after_err", 2);

        // No response at all: timeout after TMO_CYC+1 WAIT cycles
        no_resp_from = 0;
        run_line("timeout", 3, cyc);
        verify_line("timeout", 3);
        check("timeout latency", t_done - t_acc, TMO_CYC + 2);
        no_resp_from = DEPTH + 1;

        // Zero-length line: done only, no command, never busy
        run_line("zero_len", 0, cyc);
        check("zero_len rd cycles", rd_total, 0);
        check("zero_len busy seen", busy_seen, 0);
        check("zero_len done pulses", done_cnt, 1);
        check("zero_len err", err, 0);

        // Reset while stuck in WAIT on address 2
        no_resp_from = 2;
        line_id++;
        @(negedge clk);
        line_len = (ADDR_W+1)'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-reset addr", maddr, 2);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        no_resp_from = DEPTH + 1;
        line_id++;
        repeat (5) @(negedge clk);
        check("post-reset done pulses", done_cnt, 0);
        check("post-reset busy", busy, 0);
        run_line("post_reset", 3, cyc);
        verify_line("post_reset", 3);

        // Randomized lines: random data, delays, backpressure, junk SResp, errors
        acc_max = 3; resp_max = 3; rdy_pct = 60; junk_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
            len = int'($urandom_range(24, 1));
            err_addr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            run_line($sformatf("rand%0d", k), len, cyc);
            verify_line($sformatf("rand%0d", k), len);
        end
        err_addr = -1;

        // Full-depth line: addresses 0..DEPTH-1, no wrap
        acc_max = 0; resp_max = 0; rdy_pct = 100; junk_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        run_line("full", DEPTH, cyc);
        verify_line("full", DEPTH);
        check("full period", cyc, 3 * DEPTH + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
